// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared types and helpers for the sequential multiply/divide
//               unit: operation encoding, control-state encoding, and small
//               decode helpers used when an operation is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // Operation encoding as presented on the op port.
    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } mdu_op_t;

    // Control states: IDLE waits for start, RUN iterates, FIX writes results.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    function automatic logic is_div(input mdu_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_signed(input mdu_op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Parametrised sequential multiply/divide unit. Multiplication
//               is LSB-first shift-add, division is MSB-first restoring; both
//               run on operand magnitudes with one radix-2 step per clock and
//               a final sign-correction cycle.
// Ports       : Clk          - rising-edge clock
//               reset        - synchronous, active-low reset
//               start        - request, sampled only while idle
//               op           - MULT / MULTU / DIV / DIVU
//               oper_A       - multiplicand / dividend
//               oper_B       - multiplier / divisor
//               busy         - operation in progress
//               done         - one-cycle pulse, hi/lo valid from this cycle
//               hi           - product upper half / remainder
//               lo           - product lower half / quotient
//               div_by_zero  - divide with oper_B == 0, qualified by done
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] oper_A,
    input  logic [WIDTH-1:0] oper_B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    mdu_state_t         state;
    logic [CNT_W-1:0]   count;
    // Multiply: {0, partial-product high, multiplier shifting out}.
    // Divide:   {partial remainder (WIDTH+1), dividend / quotient bits}.
    logic [2*WIDTH:0]   work;
    logic [WIDTH-1:0]   operand;     // multiplicand or divisor magnitude
    logic               op_div;
    logic               neg_main;    // product / quotient sign
    logic               neg_rem;     // remainder sign (dividend's sign)
    logic               dbz;

    // ------------------------------------------------------------------
    // Accept-time decode
    // ------------------------------------------------------------------
    mdu_op_t            op_in;
    logic               sgn_in;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               b_zero;

    assign op_in  = mdu_op_t'(op);
    assign sgn_in = is_signed(op_in);
    assign a_neg  = sgn_in & oper_A[WIDTH-1];
    assign b_neg  = sgn_in & oper_B[WIDTH-1];
    assign mag_a  = a_neg ? -oper_A : oper_A;
    assign mag_b  = b_neg ? -oper_B : oper_B;
    assign b_zero = (oper_B == '0);

    // ------------------------------------------------------------------
    // One radix-2 step for each operation
    // ------------------------------------------------------------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH:0]   mul_next;
    logic [2*WIDTH:0]   div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH:0]   div_next;

    always_comb begin
        // work[2*WIDTH] is always zero here, so the sum cannot overflow.
        mul_sum   = work[2*WIDTH:WIDTH] + (work[0] ? {1'b0, operand} : '0);
        mul_next  = {1'b0, mul_sum, work[WIDTH-1:1]};

        div_shift = {work[2*WIDTH-1:0], 1'b0};
        div_trial = div_shift[2*WIDTH:WIDTH] - {1'b0, operand};
        div_next  = div_shift;
        if (div_shift[2*WIDTH:WIDTH] >= {1'b0, operand}) begin
            div_next = {div_trial, div_shift[WIDTH-1:1], 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Sign correction of the magnitude results
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign prod_mag = work[2*WIDTH-1:0];
    assign prod_fix = neg_main ? -prod_mag : prod_mag;
    // MIN / -1 yields a quotient magnitude of MIN with a positive sign,
    // which is already the wrapped result.
    assign quo_fix  = neg_main ? -work[WIDTH-1:0] : work[WIDTH-1:0];
    assign rem_fix  = neg_rem ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!reset) begin
            state       <= IDLE;
            count       <= '0;
            work        <= '0;
            operand     <= '0;
            op_div      <= 1'b0;
            neg_main    <= 1'b0;
            neg_rem     <= 1'b0;
            dbz         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        count    <= '0;
                        op_div   <= is_div(op_in);
                        neg_main <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        dbz      <= 1'b0;
                        if (is_div(op_in)) begin
                            work    <= {{(WIDTH+1){1'b0}}, mag_a};
                            operand <= mag_b;
                            if (b_zero) begin
                                // Raw dividend is parked in work so hi can
                                // return it unchanged.
                                work  <= {{(WIDTH+1){1'b0}}, oper_A};
                                dbz   <= 1'b1;
                                state <= FIX;
                            end else begin
                                state <= RUN;
                            end
                        end else begin
                            work    <= {{(WIDTH+1){1'b0}}, mag_b};
                            operand <= mag_a;
                            state   <= RUN;
                        end
                    end
                end

                RUN: begin
                    work  <= op_div ? div_next : mul_next;
                    count <= count + CNT_ONE;
                    if (count == CNT_LAST) begin
                        state <= FIX;
                    end
                end

                FIX: begin
                    if (dbz) begin
                        hi          <= work[WIDTH-1:0];
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else if (op_div) begin
                        hi          <= rem_fix;
                        lo          <= quo_fix;
                        div_by_zero <= 1'b0;
                    end else begin
                        hi          <= prod_fix[2*WIDTH-1:WIDTH];
                        lo          <= prod_fix[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit at WIDTH=32 and WIDTH=8,
//               comparing against plain-arithmetic reference models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        start32;
    logic [1:0]  op32;
    logic [31:0] a32, b32;
    logic        busy32, done32, dbz32;
    logic [31:0] hi32, lo32;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, dbz8;
    logic [7:0]  hi8, lo8;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.WIDTH(32)) dut32 (
        .Clk(clk), .reset(rst_n), .start(start32), .op(op32),
        .oper_A(a32), .oper_B(b32), .busy(busy32), .done(done32),
        .hi(hi32), .lo(lo32), .div_by_zero(dbz32)
    );

    mult_div_unit #(.WIDTH(8)) dut8 (
        .Clk(clk), .reset(rst_n), .start(start8), .op(op8),
        .oper_A(a8), .oper_B(b8), .busy(busy8), .done(done8),
        .hi(hi8), .lo(lo8), .div_by_zero(dbz8)
    );

    // ---------------- reference models ----------------
    function automatic void ref32(input logic [1:0] o, input logic [31:0] a, b,
                                  output logic [31:0] eh, el, output logic ez);
        longint      sa, sb, p, q, r;
        logic [63:0] ua, ub, pu;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        ez = 1'b0;
        eh = '0;
        el = '0;
        case (o)
            2'd0: begin p = sa * sb; eh = 32'(p >>> 32); el = 32'(p); end
            2'd1: begin pu = ua * ub; eh = pu[63:32]; el = pu[31:0]; end
            2'd2: begin
                if (b == 0) begin ez = 1'b1; eh = a; el = '1; end
                else begin q = sa / sb; r = sa % sb; eh = 32'(r); el = 32'(q); end
            end
            default: begin
                if (b == 0) begin ez = 1'b1; eh = a; el = '1; end
                else begin pu = ua / ub; el = pu[31:0]; pu = ua % ub; eh = pu[31:0]; end
            end
        endcase
    endfunction

    function automatic void ref8(input logic [1:0] o, input logic [7:0] a, b,
                                 output logic [7:0] eh, el, output logic ez);
        int sa, sb, ua, ub, p, q, r;
        sa = $signed(a);
        sb = $signed(b);
        ua = {24'b0, a};
        ub = {24'b0, b};
        ez = 1'b0;
        eh = '0;
        el = '0;
        case (o)
            2'd0: begin p = sa * sb; eh = 8'(p >>> 8); el = 8'(p); end
            2'd1: begin p = ua * ub; eh = 8'(p >>> 8); el = 8'(p); end
            2'd2: begin
                if (b == 0) begin ez = 1'b1; eh = a; el = '1; end
                else begin q = sa / sb; r = sa % sb; eh = 8'(r); el = 8'(q); end
            end
            default: begin
                if (b == 0) begin ez = 1'b1; eh = a; el = '1; end
                else begin q = ua / ub; r = ua % ub; eh = 8'(r); el = 8'(q); end
            end
        endcase
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // ---------------- stimulus drivers ----------------
    // Issue one operation; lat = edges from accept to done (-1 on timeout),
    // busy_bad = cycles before done where busy was low.
    task automatic do_op32(input logic [1:0] o, input logic [31:0] a, b,
                           output int lat, output int busy_bad);
        @(negedge clk);
        start32 = 1'b1; op32 = o; a32 = a; b32 = b;
        @(negedge clk);
        start32 = 1'b0; op32 = 2'($urandom); a32 = $urandom; b32 = $urandom;
        lat = 0;
        busy_bad = busy32 ? 0 : 1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            lat++;
            if (done32) break;
            if (!busy32) busy_bad++;
        end
        if (!done32) lat = -1;
    endtask

    task automatic do_op8(input logic [1:0] o, input logic [7:0] a, b,
                          output int lat);
        @(negedge clk);
        start8 = 1'b1; op8 = o; a8 = a; b8 = b;
        @(negedge clk);
        start8 = 1'b0; op8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            lat++;
            if (done8) break;
        end
        if (!done8) lat = -1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy32, done32, dbz32, hi32, lo32} !== 67'd0) begin
            errors++;
            $display("FAIL reset32: busy=%b done=%b dbz=%b hi=%h lo=%h, want all zero",
                     busy32, done32, dbz32, hi32, lo32);
        end
        checks++;
        if ({busy8, done8, dbz8, hi8, lo8} !== 19'd0) begin
            errors++;
            $display("FAIL reset8: busy=%b done=%b dbz=%b hi=%h lo=%h, want all zero",
                     busy8, done8, dbz8, hi8, lo8);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mult_directed();
        int lat, bb;
        do_op32(MULT, 32'hFFFF_FFFD, 32'h0000_0007, lat, bb);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL mult_latency: got %0d want 33", lat); end
        checks++;
        if (bb !== 0) begin errors++; $display("FAIL mult_busy: low %0d cycles want 0", bb); end
        checks++;
        if ({hi32, lo32, dbz32} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0}) begin
            errors++;
            $display("FAIL mult_neg3x7: hi=%h lo=%h dbz=%b want FFFFFFFF FFFFFFEB 0", hi32, lo32, dbz32);
        end
        @(posedge clk); #1;
        checks++;
        if ({done32, busy32} !== 2'b00) begin
            errors++;
            $display("FAIL done_pulse: done=%b busy=%b want 0 0", done32, busy32);
        end
        do_op32(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bb);
        checks++;
        if ({hi32, lo32} !== {32'hFFFF_FFFE, 32'h0000_0001}) begin
            errors++;
            $display("FAIL multu_max: hi=%h lo=%h want FFFFFFFE 00000001", hi32, lo32);
        end
        do_op32(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bb);
        checks++;
        if ({hi32, lo32} !== {32'h0000_0000, 32'h0000_0001}) begin
            errors++;
            $display("FAIL mult_m1xm1: hi=%h lo=%h want 00000000 00000001", hi32, lo32);
        end
    endtask

    task automatic test_div_directed();
        int lat, bb;
        do_op32(DIV, 32'hFFFF_FFF9, 32'h0000_0002, lat, bb);
        checks++;
        if ({hi32, lo32, lat} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd33}) begin
            errors++;
            $display("FAIL div_neg7by2: hi=%h lo=%h lat=%0d want FFFFFFFF FFFFFFFD 33", hi32, lo32, lat);
        end
        do_op32(DIVU, 32'd7, 32'd2, lat, bb);
        checks++;
        if ({hi32, lo32} !== {32'd1, 32'd3}) begin
            errors++;
            $display("FAIL divu_7by2: hi=%h lo=%h want 1 3", hi32, lo32);
        end
        do_op32(DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bb);
        checks++;
        if ({hi32, lo32, dbz32} !== {32'h0, 32'h8000_0000, 1'b0}) begin
            errors++;
            $display("FAIL div_overflow: hi=%h lo=%h dbz=%b want 0 80000000 0", hi32, lo32, dbz32);
        end
    endtask

    task automatic test_div_zero();
        int lat, bb;
        do_op32(DIVU, 32'd5, 32'd0, lat, bb);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL dbz_latency: got %0d want 1", lat); end
        checks++;
        if ({dbz32, hi32, lo32} !== {1'b1, 32'd5, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL dbz_result: dbz=%b hi=%h lo=%h want 1 5 FFFFFFFF", dbz32, hi32, lo32);
        end
        do_op32(MULTU, 32'd2, 32'd3, lat, bb);
        checks++;
        if ({dbz32, hi32, lo32} !== {1'b0, 32'd0, 32'd6}) begin
            errors++;
            $display("FAIL dbz_clear: dbz=%b hi=%h lo=%h want 0 0 6", dbz32, hi32, lo32);
        end
    endtask

    task automatic test_random32();
        int lat, bb;
        logic [1:0]  o;
        logic [31:0] a, b, eh, el;
        logic        ez;
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom);
            a = pick32();
            b = pick32();
            ref32(o, a, b, eh, el, ez);
            do_op32(o, a, b, lat, bb);
            checks++;
            if ({hi32, lo32, dbz32} !== {eh, el, ez} || lat !== (ez ? 1 : 33) || bb !== 0) begin
                errors++;
                $display("FAIL rand32[%0d] op=%0d a=%h b=%h: hi=%h lo=%h dbz=%b lat=%0d busy_low=%0d want hi=%h lo=%h dbz=%b lat=%0d",
                         i, o, a, b, hi32, lo32, dbz32, lat, bb, eh, el, ez, ez ? 1 : 33);
            end
        end
    endtask

    task automatic test_ignore_and_back_to_back();
        int lat;
        logic [31:0] a, b, eh, el;
        logic        ez;
        a = $urandom; b = $urandom;
        ref32(MULT, a, b, eh, el, ez);
        @(negedge clk);
        start32 = 1'b1; op32 = MULT; a32 = a; b32 = b;
        @(posedge clk); #1;
        start32 = 1'b0;
        lat = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            lat++;
            if (done32) break;
            if (lat == 4) begin
                start32 = 1'b1; op32 = DIVU; a32 = $urandom; b32 = 32'd0;
            end else begin
                start32 = 1'b0;
            end
        end
        if (!done32) lat = -1;
        checks++;
        if ({hi32, lo32, dbz32} !== {eh, el, 1'b0} || lat !== 33) begin
            errors++;
            $display("FAIL busy_start_ignored: hi=%h lo=%h dbz=%b lat=%0d want %h %h 0 33",
                     hi32, lo32, dbz32, lat, eh, el);
        end
        // Reissue while done is still high.
        a = $urandom; b = $urandom;
        ref32(MULTU, a, b, eh, el, ez);
        start32 = 1'b1; op32 = MULTU; a32 = a; b32 = b;
        @(posedge clk); #1;
        start32 = 1'b0;
        lat = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            lat++;
            if (done32) break;
        end
        if (!done32) lat = -1;
        checks++;
        if ({hi32, lo32} !== {eh, el} || lat !== 33) begin
            errors++;
            $display("FAIL back_to_back: hi=%h lo=%h lat=%0d want %h %h 33", hi32, lo32, lat, eh, el);
        end
        // Results hold while idle with changing inputs.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            op32 = 2'($urandom); a32 = $urandom; b32 = $urandom;
        end
        #1;
        checks++;
        if ({hi32, lo32, done32, busy32} !== {eh, el, 2'b00}) begin
            errors++;
            $display("FAIL hold: hi=%h lo=%h done=%b busy=%b want %h %h 0 0",
                     hi32, lo32, done32, busy32, eh, el);
        end
    endtask

    task automatic test_reset_mid32();
        int seen;
        @(negedge clk);
        start32 = 1'b1; op32 = MULT; a32 = $urandom; b32 = $urandom;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if ({busy32, done32, dbz32, hi32, lo32} !== 67'd0) begin
            errors++;
            $display("FAIL reset_mid32: busy=%b done=%b dbz=%b hi=%h lo=%h want all zero",
                     busy32, done32, dbz32, hi32, lo32);
        end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done32 || busy32) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL reset_abandon32: active %0d cycles want 0", seen); end
    endtask

    task automatic test_width8();
        int lat, seen;
        logic [1:0] o;
        logic [7:0] a, b, eh, el;
        logic       ez;
        do_op8(MULT, 8'h80, 8'h80, lat);
        checks++;
        if ({hi8, lo8, lat} !== {8'h40, 8'h00, 32'd9}) begin
            errors++;
            $display("FAIL w8_mult80x80: hi=%h lo=%h lat=%0d want 40 00 9", hi8, lo8, lat);
        end
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom);
            a = 8'($urandom);
            b = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
            ref8(o, a, b, eh, el, ez);
            do_op8(o, a, b, lat);
            checks++;
            if ({hi8, lo8, dbz8} !== {eh, el, ez} || lat !== (ez ? 1 : 9)) begin
                errors++;
                $display("FAIL rand8[%0d] op=%0d a=%h b=%h: hi=%h lo=%h dbz=%b lat=%0d want %h %h %b %0d",
                         i, o, a, b, hi8, lo8, dbz8, lat, eh, el, ez, ez ? 1 : 9);
            end
        end
        @(negedge clk);
        start8 = 1'b1; op8 = MULTU; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if ({busy8, done8, dbz8, hi8, lo8} !== 19'd0) begin
            errors++;
            $display("FAIL reset_mid8: busy=%b done=%b dbz=%b hi=%h lo=%h want all zero",
                     busy8, done8, dbz8, hi8, lo8);
        end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done8 || busy8) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL reset_abandon8: active %0d cycles want 0", seen); end
    endtask

    initial begin
        rst_n   = 1'b0;
        start32 = 1'b0; op32 = 2'd0; a32 = '0; b32 = '0;
        start8  = 1'b0; op8  = 2'd0; a8  = '0; b8  = '0;
        test_reset();
        test_mult_directed();
        test_div_directed();
        test_div_zero();
        test_random32();
        test_ignore_and_back_to_back();
        test_reset_mid32();
        test_width8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
